byte_pack_fast: RTL and testbench

//  Consumes the byte stream leaving the slow-to-fast demux (one-cycle data_in_valid pulses in the
//  clk_b domain) and packs BYTES_PER_WORD bytes into a wide word. Completed words are buffered in a

---
 rtl/byte_pack_pkg.sv | 23 ++
 rtl/byte_pack_fast_fifo.sv | 58 +++++
 rtl/byte_pack_fast.sv | 118 +++++++++++
 tb/tb_byte_pack_fast.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/byte_pack_pkg.sv
// Shared definitions for the byte packer: byte width, accumulator state encoding
// and the lane-count -> thermometer keep-mask helper.
package byte_pack_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_LANES = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } pack_state_t;

    // lanes=3 -> ...0111
    function automatic logic [MAX_LANES-1:0] keep_mask(input int lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_pack_fast_fifo.sv
// Single-clock first-word-fall-through FIFO holding packed words (data+keep).
// Read data is forced to 0 while empty; o_drop flags a push refused because full.
module pack_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk_b,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_pop;
    logic          w_wr;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;

    // A pop on a full FIFO frees the slot the same-cycle push needs.
    assign w_pop  = i_pop && !o_empty;
    assign w_wr   = i_push && (!o_full || w_pop);
    assign o_drop = i_push && o_full && !w_pop;

    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk_b) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/byte_pack_fast.sv
// Packs a byte stream into BYTES_PER_WORD-wide words (first byte in lane 0) and
// buffers them in a FWFT FIFO. Optional idle flush of partial words: PACK_TIMEOUT_EN.
module byte_pack_fast
    import byte_pack_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                               clk_b,
    input  logic                               rst,
    input  logic [BYTE_W-1:0]                  data_in,
    input  logic                               data_in_valid,
    output logic [BYTE_W*BYTES_PER_WORD-1:0]   word_out,
    output logic [BYTES_PER_WORD-1:0]          word_keep,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic                               overflow
);
    localparam int B  = BYTES_PER_WORD;
    localparam int LW = $clog2(B);
    localparam int WW = B * BYTE_W;
    localparam int FW = WW + B;
    localparam logic [B-1:0] KEEP_ALL = B'(keep_mask(B));

    logic [WW-1:0] r_acc;
    logic [LW-1:0] r_lane_cnt;
    pack_state_t   r_state;
    logic          r_overflow;

    logic [WW-1:0] w_word;
    logic          w_last;
    logic          w_flush;
    logic [B-1:0]  w_flush_keep;
    logic          w_push;
    logic [FW-1:0] w_push_data;
    logic [FW-1:0] w_rdata;
    logic          w_empty;
    logic          w_full;
    logic          w_drop;

    assign w_last = data_in_valid && (r_lane_cnt == LW'(B - 1));

    // Accumulator with the incoming byte merged into its lane.
    always_comb begin
        w_word = r_acc;
        w_word[r_lane_cnt*BYTE_W +: BYTE_W] = data_in;
    end

`ifdef PACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_idle;

    // Fires on the TIMEOUT-th consecutive idle cycle while a word is partly filled.
    assign w_flush      = (r_state == ST_FILL) && !data_in_valid && (r_idle == TW'(TIMEOUT - 1));
    assign w_flush_keep = B'(keep_mask(int'(r_lane_cnt)));

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst)
            r_idle <= '0;
        else if (data_in_valid || r_state == ST_EMPTY || w_flush)
            r_idle <= '0;
        else
            r_idle <= r_idle + 1'b1;
    end
`else
    // Partial words simply wait for their remaining bytes.
    localparam bit FLUSH_EN = 1'b0 && (TIMEOUT > 0);
    assign w_flush      = FLUSH_EN;
    assign w_flush_keep = KEEP_ALL;
`endif

    assign w_push      = w_last || w_flush;
    assign w_push_data = w_last ? {KEEP_ALL, w_word} : {w_flush_keep, r_acc};

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_lane_cnt <= '0;
            r_state    <= ST_EMPTY;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            // A dropped word still clears the accumulator.
            if (w_push) begin
                r_acc      <= '0;
                r_lane_cnt <= '0;
                r_state    <= ST_EMPTY;
            end else if (data_in_valid) begin
                r_acc      <= w_word;
                r_lane_cnt <= r_lane_cnt + 1'b1;
                r_state    <= ST_FILL;
            end
        end
    end

    pack_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_b   (clk_b),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (word_ready),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (fifo_level),
        .o_drop  (w_drop)
    );

    assign {word_keep, word_out} = w_rdata;
    assign word_valid            = !w_empty;
    assign overflow              = r_overflow;

endmodule

// File: tb/tb_byte_pack_fast.sv
// Scoreboard bench for byte_pack_fast: expected words are queued when stimulus is
// issued; a monitor pops and compares on each word_valid && word_ready at negedge.
module tb_byte_pack_fast;

    logic        clk_b = 1'b0;
    logic        rst   = 1'b1;
    logic [7:0]  data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [31:0] word_out;
    logic [3:0]  word_keep;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    logic [35:0] exp_q[$];

    byte_pack_fast #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk_b         (clk_b),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .word_out      (word_out),
        .word_keep     (word_keep),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    always #5 clk_b = ~clk_b;

    always @(negedge clk_b) begin
        if (!rst && word_valid && word_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got keep=%h word=%h required none", word_keep, word_out);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({word_keep, word_out} !== e) begin
                    bad++;
                    $display("FAIL word got keep=%h word=%h required keep=%h word=%h",
                             word_keep, word_out, e[35:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // One clock with the given input; called and returns at posedge+1.
    task automatic cyc(input logic v, input logic [7:0] d);
        data_in_valid = v;
        data_in       = d;
        @(posedge clk_b); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) cyc(1'b1, w[i*8 +: 8]);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        data_in_valid = 1'b0;
        repeat (2) @(posedge clk_b);
        #1;
        chk({tag, "_rst_word_out"}, 64'(word_out), 64'h0);
        chk({tag, "_rst_word_keep"}, 64'(word_keep), 64'h0);
        chk({tag, "_rst_word_valid"}, 64'(word_valid), 64'h0);
        chk({tag, "_rst_level"}, 64'(fifo_level), 64'h0);
        chk({tag, "_rst_overflow"}, 64'(overflow), 64'h0);
        rst = 1'b0;
        @(posedge clk_b); #1;
    endtask

    task automatic drain(input string tag);
        int n;
        word_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || word_valid) && n < 50) begin
            cyc(1'b0, 8'h00);
            n++;
        end
        chk({tag, "_drained_queue"}, 64'(exp_q.size()), 64'h0);
        chk({tag, "_drained_valid"}, 64'(word_valid), 64'h0);
    endtask

    initial begin
        do_reset("t0");

        // 1: back-to-back bytes, one-cycle latency, single valid cycle
        word_ready = 1'b1;
        exp_q.push_back({4'hF, 32'h44332211});
        cyc(1, 8'h11); cyc(1, 8'h22); cyc(1, 8'h33); cyc(1, 8'h44);
        @(negedge clk_b);
        chk("t1_valid_after_last", 64'(word_valid), 64'h1);
        @(posedge clk_b); #1;
        @(negedge clk_b);
        chk("t1_valid_one_cycle", 64'(word_valid), 64'h0);
        @(posedge clk_b); #1;

        // 2: bytes every other cycle
        exp_q.push_back({4'hF, 32'h36363636});
        for (int i = 0; i < 3; i++) begin cyc(1, 8'h36); cyc(0, 8'h00); end
        chk("t2_no_early_output", 64'(word_valid), 64'h0);
        cyc(1, 8'h36);
        drain("t2");

        // 3: overflow with ready low
        word_ready = 1'b0;
        exp_q.push_back({4'hF, 32'h13121110});
        exp_q.push_back({4'hF, 32'h23222120});
        exp_q.push_back({4'hF, 32'h33323130});
        exp_q.push_back({4'hF, 32'h43424140});
        send_word(32'h13121110);
        send_word(32'h23222120);
        send_word(32'h33323130);
        send_word(32'h43424140);
        chk("t3_level_full", 64'(fifo_level), 64'h4);
        chk("t3_no_overflow_yet", 64'(overflow), 64'h0);
        send_word(32'h53525150);
        chk("t3_level_after_drop", 64'(fifo_level), 64'h4);
        chk("t3_overflow", 64'(overflow), 64'h1);
        word_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_b);
            chk("t3_level_drain", 64'(fifo_level), 64'(4 - i));
            @(posedge clk_b); #1;
        end
        chk("t3_overflow_sticky", 64'(overflow), 64'h1);
        drain("t3");

        // 4: push and pop on a full FIFO in the same cycle
        do_reset("t4");
        word_ready = 1'b0;
        exp_q.push_back({4'hF, 32'h67666564});
        exp_q.push_back({4'hF, 32'h6B6A6968});
        exp_q.push_back({4'hF, 32'h6F6E6D6C});
        exp_q.push_back({4'hF, 32'h73727170});
        exp_q.push_back({4'hF, 32'h77767574});
        send_word(32'h67666564);
        send_word(32'h6B6A6968);
        send_word(32'h6F6E6D6C);
        send_word(32'h73727170);
        chk("t4_level_full", 64'(fifo_level), 64'h4);
        cyc(1, 8'h74); cyc(1, 8'h75); cyc(1, 8'h76);
        word_ready = 1'b1;
        cyc(1, 8'h77);
        word_ready = 1'b0;
        @(negedge clk_b);
        chk("t4_level_stays", 64'(fifo_level), 64'h4);
        chk("t4_no_overflow", 64'(overflow), 64'h0);
        @(posedge clk_b); #1;
        drain("t4");

        // 5: partial word then idle
`ifdef PACK_TIMEOUT_EN
        exp_q.push_back({4'h3, 32'h00005554});
        cyc(1, 8'h54); cyc(1, 8'h55);
        repeat (15) cyc(0, 8'h00);
        @(negedge clk_b);
        chk("t5_no_flush_before_timeout", 64'(word_valid), 64'h0);
        @(posedge clk_b); #1;
        @(negedge clk_b);
        chk("t5_flush_valid", 64'(word_valid), 64'h1);
        @(posedge clk_b); #1;
        drain("t5");
`else
        exp_q.push_back({4'hF, 32'h57565554});
        cyc(1, 8'h54); cyc(1, 8'h55);
        repeat (24) cyc(0, 8'h00);
        chk("t5_partial_waits", 64'(word_valid), 64'h0);
        chk("t5_partial_level", 64'(fifo_level), 64'h0);
        cyc(1, 8'h56); cyc(1, 8'h57);
        drain("t5");
`endif

        // 6: reset mid-fill discards the partial word
        cyc(1, 8'hE1); cyc(1, 8'hE2); cyc(1, 8'hE3);
        do_reset("t6");
        exp_q.push_back({4'hF, 32'hA3A2A1A0});
        cyc(1, 8'hA0); cyc(1, 8'hA1); cyc(1, 8'hA2); cyc(1, 8'hA3);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
